// File: rtl/cpu_ctrl_pkg.sv
// Shared state encoding, owner tags and Moore output decode for the MBR access sequencer.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_LATCH,
    WR_ACC,
    WR_OUT,
    WR_REQ,
    DONE,
    ERR
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_EXEC  = 1'b1
  } owner_e;

  typedef struct packed {
    logic c3;
    logic c11;
    logic c12;
    logic mem_rd;
    logic mem_wr;
    logic busy;
    logic done;
    logic err;
  } ctrl_out_t;

  // Output pattern of a state; evaluated on the next state so outputs come straight from flops.
  function automatic ctrl_out_t decode_state(state_e s);
    ctrl_out_t o;
    o = '0;
    case (s)
      RD_REQ:   o.mem_rd = 1'b1;
      RD_LATCH: begin o.mem_rd = 1'b1; o.c3 = 1'b1; end
      WR_ACC:   o.c12 = 1'b1;
      WR_OUT:   o.c11 = 1'b1;
      WR_REQ:   o.mem_wr = 1'b1;
      DONE:     o.done = 1'b1;
      ERR:      begin o.done = 1'b1; o.err = 1'b1; end
      default:  o = '0;
    endcase
    o.busy = (s != IDLE);
    return o;
  endfunction

endpackage

// File: rtl/mbr_access_ctrl_if.sv
// Requester, strobe and memory-port bundle of the MBR access sequencer.
interface mbr_access_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_done;
  logic              f_err;
  logic              e_req;
  logic              e_we;
  logic [ADDR_W-1:0] e_addr;
  logic              e_done;
  logic              e_err;
  logic              C3;
  logic              C11;
  logic              C12;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic              mem_ack;
  logic              busy;

  modport master (
    output f_req, f_addr, e_req, e_we, e_addr, mem_ack,
    input  f_done, f_err, e_done, e_err, C3, C11, C12, mem_addr, mem_rd, mem_wr, busy
  );

  modport slave (
    input  f_req, f_addr, e_req, e_we, e_addr, mem_ack,
    output f_done, f_err, e_done, e_err, C3, C11, C12, mem_addr, mem_rd, mem_wr, busy
  );
endinterface

// File: rtl/mbr_access_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; a tie goes to the requester that did not win last time.
module rr_arb2
  import cpu_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_req_f,
  input  logic   i_req_e,
  input  logic   i_upd,
  output logic   o_gnt_vld,
  output owner_e o_gnt_own
);

  owner_e r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= OWN_EXEC;
    end else if (i_upd && o_gnt_vld) begin
      r_last <= o_gnt_own;
    end
  end

  always_comb begin
    o_gnt_vld = i_req_f || i_req_e;
    o_gnt_own = OWN_FETCH;
    if (i_req_f && i_req_e) begin
      o_gnt_own = (r_last == OWN_FETCH) ? OWN_EXEC : OWN_FETCH;
    end else if (i_req_e) begin
      o_gnt_own = OWN_EXEC;
    end
  end

endmodule

// File: rtl/mbr_access_ctrl.sv
// MBR / memory-port sequencer: arbitrates fetch and execute, drives C3/C11/C12 and the mem handshake.
module mbr_access_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst,
  mbr_access_ctrl_if.slave bus
);

  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;
  localparam bit TO_EN = (TIMEOUT > 0);

  state_e            r_state;
  owner_e            r_own;
  logic [ADDR_W-1:0] r_addr;
  logic [WAIT_W-1:0] r_wait;
  ctrl_out_t         r_out;

  logic   w_gnt_vld;
  owner_e w_gnt_own;
  logic   w_grant_en;
  logic   w_timeout;

  assign w_grant_en = (r_state == IDLE) && w_gnt_vld;
  // An ack in the final allowed cycle takes priority over the timeout.
  assign w_timeout  = TO_EN && (r_wait == WAIT_LAST) && !bus.mem_ack;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req_f   (bus.f_req),
    .i_req_e   (bus.e_req),
    .i_upd     (w_grant_en),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_own (w_gnt_own)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_own   <= OWN_FETCH;
      r_addr  <= '0;
      r_wait  <= '0;
      r_out   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            r_own  <= w_gnt_own;
            r_addr <= (w_gnt_own == OWN_FETCH) ? bus.f_addr : bus.e_addr;
            r_wait <= '0;
            if ((w_gnt_own == OWN_EXEC) && bus.e_we) begin
              r_state <= WR_ACC;
              r_out   <= decode_state(WR_ACC);
            end else begin
              r_state <= RD_REQ;
              r_out   <= decode_state(RD_REQ);
            end
          end
        end
        RD_REQ: begin
          if (bus.mem_ack) begin
            r_state <= RD_LATCH;
            r_out   <= decode_state(RD_LATCH);
          end else if (w_timeout) begin
            r_state <= ERR;
            r_out   <= decode_state(ERR);
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        RD_LATCH: begin
          r_state <= DONE;
          r_out   <= decode_state(DONE);
        end
        WR_ACC: begin
          r_state <= WR_OUT;
          r_out   <= decode_state(WR_OUT);
        end
        WR_OUT: begin
          r_state <= WR_REQ;
          r_out   <= decode_state(WR_REQ);
          r_wait  <= '0;
        end
        WR_REQ: begin
          if (bus.mem_ack) begin
            r_state <= DONE;
            r_out   <= decode_state(DONE);
          end else if (w_timeout) begin
            r_state <= ERR;
            r_out   <= decode_state(ERR);
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_out   <= decode_state(IDLE);
        end
      endcase
    end
  end

  assign bus.C3       = r_out.c3;
  assign bus.C11      = r_out.c11;
  assign bus.C12      = r_out.c12;
  assign bus.mem_rd   = r_out.mem_rd;
  assign bus.mem_wr   = r_out.mem_wr;
  assign bus.busy     = r_out.busy;
  assign bus.mem_addr = r_addr;
  assign bus.f_done   = r_out.done && (r_own == OWN_FETCH);
  assign bus.f_err    = r_out.err  && (r_own == OWN_FETCH);
  assign bus.e_done   = r_out.done && (r_own == OWN_EXEC);
  assign bus.e_err    = r_out.err  && (r_own == OWN_EXEC);

endmodule

// File: tb/tb_mbr_access_ctrl.sv
// Bench for mbr_access_ctrl: directed and randomized accesses against a transaction-level model.
module tb_mbr_access_ctrl;

  localparam int TO = 15;

  logic clk;
  logic rst;

  mbr_access_ctrl_if #(.ADDR_W(12)) bus ();

  mbr_access_ctrl #(.ADDR_W(12), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory and MBR environment driven by the DUT strobes
  logic [4095:0] written = '0;
  logic [15:0]   wmem [0:4095];
  logic [15:0]   mbr;
  logic [15:0]   mem_out;
  logic [15:0]   acc;

  function automatic logic [15:0] dflt(logic [11:0] a);
    if (a == 12'h010) return 16'hBEEF;
    return {a, 4'h0} ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] tb_mem_rd(logic [11:0] a);
    return written[a] ? wmem[a] : dflt(a);
  endfunction

  always @(posedge clk) begin
    if (bus.C3) mbr <= tb_mem_rd(bus.mem_addr);
    else if (bus.C12) mbr <= acc;
    if (bus.C11) mem_out <= mbr;
    if (bus.mem_wr && bus.mem_ack) begin
      wmem[bus.mem_addr]    <= mem_out;
      written[bus.mem_addr] <= 1'b1;
    end
  end

  // Reference state: expected memory contents and round-robin history
  logic [15:0] ref_mem [int];
  bit          last_own;
  bit          pend_f, pend_e;
  bit          e_we_v;
  logic [11:0] f_addr_v, e_addr_v;

  function automatic logic [15:0] ref_read(logic [11:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return dflt(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {10'b0, bus.C3, bus.C11, bus.C12, bus.mem_rd, bus.mem_wr, bus.busy,
            bus.f_done, bus.f_err, bus.e_done, bus.e_err, bus.mem_addr};
  endfunction

  task automatic do_txn(input bit new_f, input bit new_e, input bit we, input logic [11:0] fa,
                        input logic [11:0] ea, input logic [15:0] acc_in, input int ack_wait,
                        input bit spur);
    bit own, is_st, tmo, d_f, d_e;
    logic [1:0] d_err;
    logic [11:0] a;
    int exp_done, done_at, n_rd, n_wr, c3_at, c11_at, c12_at, n_ovl, n_abad, cnt;
    if (new_f && !pend_f) begin
      pend_f = 1'b1; f_addr_v = fa; bus.f_addr = fa; bus.f_req = 1'b1;
    end
    if (new_e && !pend_e) begin
      pend_e = 1'b1; e_addr_v = ea; e_we_v = we; acc = acc_in;
      bus.e_addr = ea; bus.e_we = we; bus.e_req = 1'b1;
    end
    if (!pend_f && !pend_e) return;
    own      = (pend_f && pend_e) ? !last_own : pend_e;
    last_own = own;
    is_st    = own && e_we_v;
    a        = own ? e_addr_v : f_addr_v;
    tmo      = (ack_wait >= TO);
    if (is_st) exp_done = tmo ? 3 + TO : 4 + ack_wait;
    else       exp_done = tmo ? 1 + TO : 3 + ack_wait;
    done_at = 0; n_rd = 0; n_wr = 0; c3_at = 0; c11_at = 0; c12_at = 0;
    n_ovl = 0; n_abad = 0; cnt = 0; d_f = 0; d_e = 0; d_err = 2'b00;
    bus.mem_ack = spur ? 1'($urandom_range(0, 1)) : 1'b0;
    for (int k = 1; k <= 60 && done_at == 0; k++) begin
      tick();
      if (bus.mem_rd) n_rd++;
      if (bus.mem_wr) n_wr++;
      if (bus.C3  && c3_at  == 0) c3_at  = k;
      if (bus.C11 && c11_at == 0) c11_at = k;
      if (bus.C12 && c12_at == 0) c12_at = k;
      if (int'(bus.C3) + int'(bus.C11) + int'(bus.C12) > 1) n_ovl++;
      if ((bus.mem_rd || bus.mem_wr) && bus.mem_addr !== a) n_abad++;
      if (bus.f_done || bus.e_done) begin
        done_at = k; d_f = bus.f_done; d_e = bus.e_done; d_err = {bus.f_err, bus.e_err};
      end
      if (bus.mem_rd || bus.mem_wr) begin
        bus.mem_ack = (cnt == ack_wait);
        cnt++;
      end else begin
        bus.mem_ack = spur ? 1'($urandom_range(0, 1)) : 1'b0;
        cnt = 0;
      end
    end
    if (own) begin pend_e = 1'b0; bus.e_req = 1'b0; end
    else     begin pend_f = 1'b0; bus.f_req = 1'b0; end
    check("done_latency", done_at, exp_done);
    check("done_owner", {d_f, d_e}, own ? 2'b01 : 2'b10);
    check("err_flags", d_err, tmo ? (own ? 2'b01 : 2'b10) : 2'b00);
    check("mem_rd_cycles", n_rd, is_st ? 0 : (tmo ? TO : ack_wait + 2));
    check("mem_wr_cycles", n_wr, !is_st ? 0 : (tmo ? TO : ack_wait + 1));
    check("c3_cycle", c3_at, (is_st || tmo) ? 0 : ack_wait + 2);
    check("c12_c11_cycle", {c12_at[15:0], c11_at[15:0]}, is_st ? {16'd1, 16'd2} : 32'd0);
    check("strobe_overlap", n_ovl, 0);
    check("mem_addr", n_abad, 0);
    if (is_st) begin
      if (!tmo) ref_mem[int'(a)] = acc;
      check("store_data", tb_mem_rd(a), ref_read(a));
    end else if (!tmo) begin
      check("load_data", mbr, ref_read(a));
    end
    bus.mem_ack = 1'b0;
    tick();
    check("idle_gap_busy", bus.busy, 1'b0);
    check("done_one_cycle", bus.f_done | bus.e_done, 1'b0);
  endtask

  initial begin
    bit seen, nd;
    int w;
    rst = 1'b1;
    bus.f_req = 1'b0; bus.f_addr = '0; bus.e_req = 1'b0; bus.e_we = 1'b0;
    bus.e_addr = '0; bus.mem_ack = 1'b0;
    acc = 16'h0; last_own = 1'b1; pend_f = 1'b0; pend_e = 1'b0;
    e_we_v = 1'b0; f_addr_v = '0; e_addr_v = '0;
    tick(); tick();
    check("reset_outputs", all_outs(), 32'd0);
    rst = 1'b0;
    tick();

    do_txn(1, 0, 0, 12'h010, 12'h000, 16'h0, 0, 0);
    check("fetch_beef", mbr, 16'hBEEF);
    do_txn(0, 1, 1, 12'h000, 12'h0A5, 16'h1234, 3, 0);
    check("store_1234", tb_mem_rd(12'h0A5), 16'h1234);
    check("mem_out_1234", mem_out, 16'h1234);

    // Ties: fetch, exec, fetch, then the held exec request drains
    do_txn(1, 1, 0, 12'h0A5, 12'h010, 16'h0, 1, 0);
    do_txn(1, 1, 0, 12'h0A5, 12'h010, 16'h0, 0, 0);
    do_txn(1, 1, 1, 12'h0A5, 12'h0B0, 16'h5555, 2, 0);
    do_txn(0, 0, 0, 12'h000, 12'h000, 16'h0, 0, 0);

    do_txn(1, 0, 0, 12'h020, 12'h000, 16'h0, 99, 0);
    do_txn(1, 0, 0, 12'h030, 12'h000, 16'h0, 14, 0);
    do_txn(0, 1, 1, 12'h000, 12'h040, 16'hCAFE, 14, 0);
    do_txn(0, 1, 1, 12'h000, 12'h041, 16'hDEAD, 15, 0);

    // Reset in the middle of a store
    pend_e = 1'b1; e_we_v = 1'b1; e_addr_v = 12'h3C0; acc = 16'h7777;
    bus.e_addr = 12'h3C0; bus.e_we = 1'b1; bus.e_req = 1'b1; bus.mem_ack = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      seen = bus.mem_wr;
    end
    check("rst_reach_wr_req", seen, 1'b1);
    rst = 1'b1;
    tick();
    check("rst_mid_outputs", all_outs(), 32'd0);
    rst = 1'b0; bus.e_req = 1'b0; pend_e = 1'b0; last_own = 1'b1;
    nd = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      nd = nd | bus.e_done | bus.f_done | bus.busy;
    end
    check("rst_no_done", nd, 1'b0);
    check("rst_no_write", tb_mem_rd(12'h3C0), ref_read(12'h3C0));
    do_txn(0, 1, 1, 12'h000, 12'h3C0, 16'h8888, 1, 0);
    do_txn(1, 1, 0, 12'h3C0, 12'h0A5, 16'h0, 0, 0);
    do_txn(0, 0, 0, 12'h000, 12'h000, 16'h0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: w = 0;
        1: w = 1;
        2: w = int'($urandom_range(2, 6));
        3: w = 14;
        4: w = 15;
        default: w = 99;
      endcase
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             12'h100 + 12'($urandom_range(0, 7)), 12'h100 + 12'($urandom_range(0, 7)),
             16'($urandom), w, 1'b1);
    end
    do_txn(0, 0, 0, 12'h000, 12'h000, 16'h0, 0, 0);
    do_txn(0, 0, 0, 12'h000, 12'h000, 16'h0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
